accel_host_streamer: RTL and testbench

//  Host-side transmitter/receiver for the accelerator top level. Pops rows from an upstream

---
 rtl/accel_pkg.sv | 22 ++
 rtl/row_fifo.sv | 57 +++++
 rtl/accel_host_streamer.sv | 196 +++++++++++++++++++
 tb/tb_accel_host_streamer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types and run-schedule constants for the accelerator host streamer.
package accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_SEND_X,
    S_SEND_W1,
    S_WAIT_MID,
    S_SEND_W2,
    S_WAIT_OT,
    S_RECV
  } host_state_t;

  localparam int unsigned N_ROWS       = 128;
  localparam int unsigned RMS_CYCLES   = 41;
  localparam int unsigned W2_ROWS      = 64;
  localparam int unsigned MID_WAIT     = 640;
  localparam int unsigned OT_WAIT      = 128;
  localparam int unsigned ROWS_PER_RUN = 320;

endpackage

// File: rtl/row_fifo.sv
// Synchronous first-word-fall-through row FIFO with flush; DEPTH must be a power of 2.
module row_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accel_host_streamer.sv
// Host-side streamer: stages source rows, drives the accelerator load port on its fixed
// cycle schedule without ever stalling, and captures the READ_OUT rows.
module accel_host_streamer
  import accel_pkg::*;
#(
  parameter int unsigned ARR_WIDTH  = 16,
  parameter int unsigned FXP_N      = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned PREFILL    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [ARR_WIDTH*8-1:0]     src_data,
  output logic                       acc_enable,
  output logic [6:0]                 acc_mem_addr,
  output logic [ARR_WIDTH*8-1:0]     acc_mem_data,
  output logic                       acc_mem_valid,
  input  logic                       acc_out_valid,
  input  logic [ARR_WIDTH*FXP_N-1:0] acc_vec_out,
  output logic                       out_valid,
  output logic [6:0]                 out_row,
  output logic [ARR_WIDTH*FXP_N-1:0] out_data,
  output logic                       err_underrun,
  output logic                       err_sync
);

  localparam int unsigned DW = ARR_WIDTH * 8;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  host_state_t    state;
  host_state_t    state_nxt;
  logic [6:0]     row_ctr;
  logic [5:0]     sub_ctr;
  logic [9:0]     wait_ctr;
  logic [8:0]     push_total;
  logic [DW-1:0]  hold_data;
  logic [DW-1:0]  fifo_rdata;
  logic [DW-1:0]  head_or_zero;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop_due;
  logic           accept_start;
  logic           row_last;
  logic           win_last;
  logic           wait_last;
  logic           done_pre;
  logic           in_wait;

  assign accept_start = start && !busy;
  assign src_ready    = busy && !fifo_full && (push_total < 9'(ROWS_PER_RUN));
  assign push         = src_valid && src_ready;
  assign head_or_zero = fifo_empty ? '0 : fifo_rdata;
  assign row_last     = (row_ctr == 7'(N_ROWS - 1));
  assign win_last     = (sub_ctr == 6'(RMS_CYCLES - 1));
  assign in_wait      = (state == S_WAIT_MID) || (state == S_WAIT_OT);
  assign wait_last    = (state == S_WAIT_MID) ? (wait_ctr == 10'(MID_WAIT - 1))
                                              : (wait_ctr == 10'(OT_WAIT - 1));

  // Leftover rows from an underrun run are discarded when the next run is accepted.
  row_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (accept_start),
    .push  (push),
    .wdata (src_data),
    .pop   (pop_due),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // PREFILL also covers T0: the first cycle with acc_enable high sends nothing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept_start)         state_nxt = S_PREFILL;
      S_PREFILL:  if (acc_enable)           state_nxt = S_SEND_X;
      S_SEND_X:   if (row_last)             state_nxt = S_SEND_W1;
      S_SEND_W1:  if (row_last && win_last) state_nxt = S_WAIT_MID;
      S_WAIT_MID: if (wait_last)            state_nxt = S_SEND_W2;
      S_SEND_W2:  if (row_last && win_last) state_nxt = S_WAIT_OT;
      S_WAIT_OT:  if (wait_last)            state_nxt = S_RECV;
      S_RECV:     if (row_last)             state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop_due       = 1'b0;
    acc_mem_valid = 1'b0;
    acc_mem_addr  = '0;
    acc_mem_data  = '0;
    case (state)
      S_SEND_X: begin
        pop_due       = 1'b1;
        acc_mem_valid = 1'b1;
        acc_mem_addr  = row_ctr;
        acc_mem_data  = head_or_zero;
      end
      S_SEND_W1, S_SEND_W2: begin
        if (state == S_SEND_W1 || row_ctr < 7'(W2_ROWS)) begin
          pop_due       = (sub_ctr == '0);
          acc_mem_valid = 1'b1;
          acc_mem_addr  = row_ctr;
          acc_mem_data  = (sub_ctr == '0) ? head_or_zero : hold_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_ctr   <= '0;
      sub_ctr   <= '0;
      wait_ctr  <= '0;
      hold_data <= '0;
    end else begin
      wait_ctr <= (in_wait && !wait_last) ? wait_ctr + 1'b1 : '0;
      if (pop_due) hold_data <= head_or_zero;
      case (state)
        S_SEND_X, S_RECV: row_ctr <= row_ctr + 1'b1;
        S_SEND_W1, S_SEND_W2: begin
          if (win_last) begin
            sub_ctr <= '0;
            row_ctr <= row_ctr + 1'b1;
          end else begin
            sub_ctr <= sub_ctr + 1'b1;
          end
        end
        S_WAIT_MID, S_WAIT_OT: ;
        default: begin
          row_ctr <= '0;
          sub_ctr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_enable   <= 1'b0;
      busy         <= 1'b0;
      done_pre     <= 1'b0;
      done         <= 1'b0;
      push_total   <= '0;
      err_underrun <= 1'b0;
      err_sync     <= 1'b0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_data     <= '0;
    end else begin
      if (state == S_PREFILL && fifo_count >= CW'(PREFILL)) acc_enable <= 1'b1;
      else if (state == S_RECV && row_last)                 acc_enable <= 1'b0;

      done_pre <= (state == S_RECV) && row_last;
      done     <= done_pre;
      if (accept_start)  busy <= 1'b1;
      else if (done_pre) busy <= 1'b0;

      if (accept_start) push_total <= '0;
      else if (push)    push_total <= push_total + 1'b1;

      if (accept_start) begin
        err_underrun <= 1'b0;
        err_sync     <= 1'b0;
      end else begin
        if (pop_due && fifo_empty) err_underrun <= 1'b1;
        if (busy && (acc_out_valid != (state == S_RECV))) err_sync <= 1'b1;
      end

      out_valid <= (state == S_RECV) && acc_out_valid;
      if (state == S_RECV && acc_out_valid) begin
        out_row  <= row_ctr;
        out_data <= acc_vec_out;
      end
    end
  end

endmodule

// File: tb/tb_accel_host_streamer.sv
// Randomized bench for accel_host_streamer against a cycle-indexed schedule model.
module tb_accel_host_streamer;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DW     = 128;
  localparam int OW     = 256;
  localparam int T_W1   = 129;
  localparam int T_MID  = 5377;
  localparam int T_W2   = 6017;
  localparam int T_OT   = 11265;
  localparam int T_RECV = 11393;
  localparam int T_END  = 11520;
  localparam int T_DONE = 11522;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          acc_out_valid = 1'b0;
  logic [OW-1:0] acc_vec_out = '0;
  logic          busy, done, src_ready, acc_enable, acc_mem_valid;
  logic [6:0]    acc_mem_addr, out_row;
  logic [DW-1:0] acc_mem_data;
  logic          out_valid, err_underrun, err_sync;
  logic [OW-1:0] out_data;

  always #5 clk = ~clk;

  accel_host_streamer #(
    .ARR_WIDTH  (16),
    .FXP_N      (16),
    .FIFO_DEPTH (32),
    .PREFILL    (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .acc_enable    (acc_enable),
    .acc_mem_addr  (acc_mem_addr),
    .acc_mem_data  (acc_mem_data),
    .acc_mem_valid (acc_mem_valid),
    .acc_out_valid (acc_out_valid),
    .acc_vec_out   (acc_vec_out),
    .out_valid     (out_valid),
    .out_row       (out_row),
    .out_data      (out_data),
    .err_underrun  (err_underrun),
    .err_sync      (err_sync)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: ph 0 idle, 1 prefill before enable, 2 enabled with t = cycles since T0.
  logic [DW-1:0] q[$];
  logic [DW-1:0] held;
  logic [OW-1:0] vec_hist [128];
  int ph = 0, t = 0, pushed = 0;
  bit m_busy = 0, m_uerr = 0, m_serr = 0;
  int stall_lo = -1, stall_hi = -1, glitch_t = -1;

  task automatic step(input bit st);
    int fill, r, s, exp_addr;
    bit busy_now, exp_ready, in_recv, due, exp_valid, exp_ov;
    logic [DW-1:0] exp_data;
    logic [OW-1:0] v;
    fill      = q.size();
    busy_now  = m_busy;
    exp_ready = m_busy && fill < 32 && pushed < 320;

    start    = st;
    src_data = {$urandom, $urandom, $urandom, $urandom};
    if (ph == 2 && t >= stall_lo && t < stall_hi) src_valid = 1'b0;
    else if (ph == 2 && t <= 130)                 src_valid = 1'b1;
    else                                          src_valid = ($urandom_range(0, 7) != 0);
    in_recv = (ph == 2 && t >= T_RECV && t <= T_END);
    acc_out_valid = in_recv || (ph == 2 && t == glitch_t);
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (in_recv) begin
      v[15:0] = 16'(t - T_RECV);
      vec_hist[t - T_RECV] = v;
    end
    acc_vec_out = v;

    due = 0; exp_valid = 0; exp_addr = 0; exp_data = '0;
    if (ph == 2) begin
      if (t >= 1 && t <= 128) begin
        due = 1; exp_valid = 1; exp_addr = t - 1;
        exp_data = (fill > 0) ? q[0] : '0;
      end else if ((t >= T_W1 && t < T_MID) || (t >= T_W2 && t < T_OT)) begin
        r = (t >= T_W2) ? (t - T_W2) / 41 : (t - T_W1) / 41;
        s = (t >= T_W2) ? (t - T_W2) % 41 : (t - T_W1) % 41;
        if (t < T_MID || r < 64) begin
          exp_valid = 1; exp_addr = r;
          if (s == 0) begin
            due = 1;
            held = (fill > 0) ? q[0] : '0;
          end
          exp_data = held;
        end
      end
    end
    exp_ov = (ph == 2 && t >= T_RECV + 1 && t <= T_END + 1);

    #1;
    check("acc_enable", acc_enable, ph == 2 && t <= T_END);
    check("mem_valid", acc_mem_valid, exp_valid);
    if (exp_valid) begin
      check("mem_addr", acc_mem_addr, exp_addr);
      check("mem_data", acc_mem_data, exp_data);
    end else begin
      check("mem_data_idle", acc_mem_data, '0);
    end
    check("src_ready", src_ready, exp_ready);
    check("busy", busy, m_busy);
    check("done", done, ph == 2 && t == T_DONE);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("out_row", out_row, t - T_RECV - 1);
      check("out_data", out_data, vec_hist[t - T_RECV - 1]);
    end
    check("err_underrun", err_underrun, m_uerr);
    check("err_sync", err_sync, m_serr);

    if (due) begin
      if (fill > 0) void'(q.pop_front());
      else          m_uerr = 1;
    end
    if (busy_now && (acc_out_valid != in_recv)) m_serr = 1;
    if (src_valid && exp_ready) begin
      q.push_back(src_data);
      pushed++;
    end
    if (ph == 1 && fill >= 32) begin
      ph = 2; t = 0;
    end else if (ph == 2) begin
      t++;
      if (t == T_DONE) m_busy = 0;
      if (t > T_DONE)  ph = 0;
    end
    if (st && !busy_now) begin
      ph = 1; m_busy = 1; pushed = 0; m_uerr = 0; m_serr = 0;
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, src_ready, acc_enable, acc_mem_valid, out_valid,
                           err_underrun, err_sync, acc_mem_addr, out_row}, '0);
    check({tag, "_mem_data"}, acc_mem_data, '0);
    check({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic run(input int s_lo, input int s_hi, input int glitch, input int rst_at);
    stall_lo = s_lo; stall_hi = s_hi; glitch_t = glitch;
    step(1'b1);
    for (int n = 0; n < 20000 && ph != 0 && fails < 200; n++) begin
      if (ph == 2 && t == rst_at) begin
        rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; acc_out_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_rst");
        rst_n = 1'b1;
        ph = 0; m_busy = 0; m_uerr = 0; m_serr = 0;
        q.delete();
        @(negedge clk);
        return;
      end
      step(ph == 2 && t == 500);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    run(-1, -1, -1, -1);
    run(20, 220, 5400, -1);
    run(-1, -1, -1, 3000);
    run(-1, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
